// File: rtl/spi_share_arb.sv
// Round-robin arbiter that shares one housekeeping spi_master between NREQ requesters:
// latches the winner's command, pulses start, supervises busy with timeouts, returns data/status.
`timescale 1ns/1ps

module spi_share_arb #(
   parameter int NREQ     = 2,
   parameter int START_TO = 16,
   parameter int DONE_TO  = 100000
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [16*NREQ-1:0]   dat_h_i,
   input  logic [16*NREQ-1:0]   dat_l_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 err_o,
   output logic [15:0]          rd_dat_o,
   output logic                 busy_o,
   output logic                 spi_start_o,
   output logic [15:0]          spi_wr_h_o,
   output logic [15:0]          spi_wr_l_o,
   input  logic [15:0]          spi_rd_l_i,
   input  logic                 spi_bsy_i
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(DONE_TO + 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_START     = 3'd2;
   localparam logic [2:0] ST_WAIT_BSY  = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
   localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TO - 1);

   logic [2:0]       state_r;
   logic [IDX_W-1:0] last_r;
   logic [IDX_W-1:0] win_r;
   logic [CNT_W-1:0] cnt_r;

   logic [IDX_W-1:0] win_s;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;
   logic [NREQ-1:0]  win_oh_s;
   logic [15:0]      sel_h_s;
   logic [15:0]      sel_l_s;
   logic [CNT_W-1:0] cnt_inc_s;

   // Round-robin search starting one past the last granted requester
   always_comb begin
      win_s   = last_r;
      idx_s   = last_r;
      found_s = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s   = IDX_W'((int'(last_r) + k) % NREQ);
         win_s   = (!found_s && req_i[idx_s]) ? idx_s : win_s;
         found_s = found_s | req_i[idx_s];
      end
   end

   // Winner one-hot and command-word slice selection for the latched grant
   always_comb begin
      sel_h_s  = 16'h0000;
      sel_l_s  = 16'h0000;
      win_oh_s = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_h_s     = (win_r == IDX_W'(i)) ? dat_h_i[16*i +: 16] : sel_h_s;
         sel_l_s     = (win_r == IDX_W'(i)) ? dat_l_i[16*i +: 16] : sel_l_s;
         win_oh_s[i] = (win_s == IDX_W'(i));
      end
   end

   // Saturating timeout counter increment
   always_comb begin
      cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
   end

   // Transaction sequencer; every output is a register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_r     <= ST_IDLE;
         last_r      <= IDX_W'(NREQ - 1);
         win_r       <= {IDX_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         gnt_o       <= {NREQ{1'b0}};
         done_o      <= {NREQ{1'b0}};
         err_o       <= 1'b0;
         rd_dat_o    <= 16'h0000;
         busy_o      <= 1'b0;
         spi_start_o <= 1'b0;
         spi_wr_h_o  <= 16'h0000;
         spi_wr_l_o  <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  win_r   <= win_s;
                  last_r  <= win_s;
                  gnt_o   <= win_oh_s;
                  busy_o  <= 1'b1;
                  state_r <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               spi_wr_h_o  <= sel_h_s;
               spi_wr_l_o  <= sel_l_s;
               spi_start_o <= 1'b1;
               state_r     <= ST_START;
            end
            ST_START: begin
               spi_start_o <= 1'b0;
               cnt_r       <= {CNT_W{1'b0}};
               state_r     <= ST_WAIT_BSY;
            end
            // Busy already high here counts as the rise
            ST_WAIT_BSY: begin
               if (spi_bsy_i) begin
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= ST_WAIT_DONE;
               end else if (cnt_r >= START_LIM) begin
                  done_o  <= gnt_o;
                  err_o   <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_WAIT_DONE: begin
               if (!spi_bsy_i) begin
                  rd_dat_o <= spi_rd_l_i;
                  done_o   <= gnt_o;
                  err_o    <= 1'b0;
                  state_r  <= ST_DONE;
               end else if (cnt_r >= DONE_LIM) begin
                  done_o  <= gnt_o;
                  err_o   <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_DONE: begin
               done_o  <= {NREQ{1'b0}};
               err_o   <= 1'b0;
               gnt_o   <= {NREQ{1'b0}};
               busy_o  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_o      <= {NREQ{1'b0}};
               err_o       <= 1'b0;
               gnt_o       <= {NREQ{1'b0}};
               busy_o      <= 1'b0;
               spi_start_o <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   spi_share_arb_chk #(.NREQ(NREQ)) u_chk (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .gnt       (gnt_o),
      .done      (done_o),
      .spi_start (spi_start_o),
      .busy      (busy_o)
   );

endmodule

// Structural invariants of the arbiter outputs
module spi_share_arb_chk #(
   parameter int NREQ = 2
) (
   input logic            clk_i,
   input logic            rstn_i,
   input logic [NREQ-1:0] gnt,
   input logic [NREQ-1:0] done,
   input logic            spi_start,
   input logic            busy
);

   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(gnt));
   a_done_in_gnt: assert property (@(posedge clk_i) disable iff (!rstn_i) (done & ~gnt) == {NREQ{1'b0}});
   a_start_busy: assert property (@(posedge clk_i) disable iff (!rstn_i) spi_start |-> busy);

endmodule

// File: tb/tb_spi_share_arb.sv
// Self-checking bench for spi_share_arb: directed vector table, contention/reset sequences,
// and randomized transactions against an arithmetic reference model.
`timescale 1ns/1ps

module tb_spi_share_arb;

   localparam int NREQ     = 2;
   localparam int START_TO = 16;
   localparam int DONE_TO  = 100;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic [1:0]  req_i;
   logic [31:0] dat_h_i, dat_l_i;
   logic [1:0]  gnt_o, done_o;
   logic        err_o, busy_o, spi_start_o;
   logic [15:0] rd_dat_o, spi_wr_h_o, spi_wr_l_o, spi_rd_l_i;
   logic        spi_bsy_i;

   int n_chk = 0;
   int n_err = 0;
   // master model: busy is high from m_dly to m_dly+m_len-1 cycles after the start cycle
   int m_dly = -1;
   int m_len = 0;
   int m_t   = -1;

   always #5 clk = ~clk;

   spi_share_arb #(.NREQ(NREQ), .START_TO(START_TO), .DONE_TO(DONE_TO)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .dat_h_i(dat_h_i), .dat_l_i(dat_l_i),
      .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rd_dat_o(rd_dat_o), .busy_o(busy_o),
      .spi_start_o(spi_start_o), .spi_wr_h_o(spi_wr_h_o), .spi_wr_l_o(spi_wr_l_o),
      .spi_rd_l_i(spi_rd_l_i), .spi_bsy_i(spi_bsy_i)
   );

   typedef struct {
      logic [1:0]  req;
      logic [15:0] dh;
      logic [15:0] dl;
      int          dly;
      int          len;
      logic [15:0] rd;
      int          win;
      logic        err;
      logic [15:0] exp_rd;
      int          lat;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Behavioural spi_master: busy pattern measured from the cycle start is seen
   initial begin
      spi_bsy_i = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_start_o === 1'b1) m_t = 0;
         else if (m_t >= 0) m_t++;
         spi_bsy_i = (m_t >= 0) && (m_dly >= 0) && (m_t >= m_dly) && (m_t < m_dly + m_len);
      end
   end

   // One transaction issued with the DUT idle; lat counts cycles from start to done
   task automatic do_txn(input string nm, input logic [1:0] rq, input logic [31:0] dh,
                         input logic [31:0] dl, input int dly, input int len,
                         input logic [15:0] rd, input int ew, input logic ee,
                         input logic [15:0] er, input int el);
      logic [1:0]  oh;
      logic [15:0] ewh, ewl;
      int          j, extra;
      oh  = 2'b01 << ew;
      ewh = dh[16*ew +: 16];
      ewl = dl[16*ew +: 16];
      dat_h_i = dh; dat_l_i = dl; m_dly = dly; m_len = len; spi_rd_l_i = rd; req_i = rq;
      @(negedge clk);
      chk($sformatf("%s_load_gnt", nm), {gnt_o, spi_start_o, busy_o}, {oh, 1'b0, 1'b1});
      @(negedge clk);
      chk($sformatf("%s_start", nm), spi_start_o, 1'b1);
      chk($sformatf("%s_wr", nm), {spi_wr_h_o, spi_wr_l_o}, {ewh, ewl});
      dat_h_i = ~dh; dat_l_i = ~dl;
      j = 0; extra = 0;
      do begin
         @(negedge clk);
         j++;
         if (spi_start_o) extra++;
      end while (done_o == 2'b00 && j < 400);
      chk($sformatf("%s_lat", nm), j, el);
      chk($sformatf("%s_one_start", nm), extra, 0);
      chk($sformatf("%s_done", nm), {done_o, gnt_o, err_o}, {oh, oh, ee});
      chk($sformatf("%s_rd", nm), rd_dat_o, er);
      chk($sformatf("%s_wr_hold", nm), {spi_wr_h_o, spi_wr_l_o}, {ewh, ewl});
      req_i = 2'b00;
      @(negedge clk);
      chk($sformatf("%s_idle", nm), {busy_o, gnt_o, done_o}, 5'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, want finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_done, n_start, n_seen, ref_last, win, dly, len, lat;
      logic [1:0]  rerq, rq;
      logic [15:0] ref_rd, rd;
      logic [31:0] dh, dl;
      logic        err, found;

      tbl[0] = '{2'b01, 16'h0012, 16'h00A5,  3,     48, 16'h1111, 0, 1'b0, 16'h1111,  52};
      tbl[1] = '{2'b10, 16'h8001, 16'h0040,  2,     10, 16'h00C3, 1, 1'b0, 16'h00C3,  13};
      tbl[2] = '{2'b01, 16'h0102, 16'h0304, -1,      0, 16'hDEAD, 0, 1'b1, 16'h00C3,  17};
      tbl[3] = '{2'b11, 16'h0A0B, 16'h0C0D,  1, 100000, 16'hBEEF, 1, 1'b1, 16'h00C3, 102};
      tbl[4] = '{2'b11, 16'h1357, 16'h2468,  1,      1, 16'h7E57, 0, 1'b0, 16'h7E57,   3};
      tbl[5] = '{2'b10, 16'h8F00, 16'h00F0, 16,      5, 16'h0A0A, 1, 1'b0, 16'h0A0A,  22};
      tbl[6] = '{2'b01, 16'h0055, 16'h00AA, 17,      5, 16'h5555, 0, 1'b1, 16'h0A0A,  17};
      tbl[7] = '{2'b10, 16'h4321, 16'h8765,  1,    100, 16'h1234, 1, 1'b0, 16'h1234, 102};
      tbl[8] = '{2'b01, 16'h6666, 16'h7777,  1,    101, 16'h9999, 0, 1'b1, 16'h1234, 102};

      rstn_i = 1'b0; req_i = 2'b11; dat_h_i = 32'h0; dat_l_i = 32'h0; spi_rd_l_i = 16'h0000;
      m_dly = 2; m_len = 3;
      repeat (2) @(negedge clk);
      chk("reset_outs", {gnt_o, done_o, err_o, rd_dat_o, busy_o, spi_start_o, spi_wr_h_o, spi_wr_l_o}, 64'h0);
      rstn_i = 1'b1;

      // Contention: both request from reset and re-request right after their done
      n_done = 0; n_start = 0; rerq = 2'b00;
      for (int c = 0; c < 300 && n_done < 4; c++) begin
         @(negedge clk);
         chk("cont_gnt_onehot", $onehot0(gnt_o), 1'b1);
         if (spi_start_o) n_start++;
         if (rerq != 2'b00) begin
            req_i = req_i | rerq;
            rerq  = 2'b00;
         end
         if (done_o != 2'b00) begin
            chk("cont_order", done_o, (n_done % 2 == 0) ? 2'b01 : 2'b10);
            n_done++;
            rerq  = (n_done < 4) ? done_o : 2'b00;
            req_i = (n_done < 4) ? (req_i & ~done_o) : 2'b00;
         end
      end
      chk("cont_done_cnt", n_done, 4);
      chk("cont_start_eq_done", n_start, n_done);
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         dh = (tbl[i].win == 0) ? {~tbl[i].dh, tbl[i].dh} : {tbl[i].dh, ~tbl[i].dh};
         dl = (tbl[i].win == 0) ? {~tbl[i].dl, tbl[i].dl} : {tbl[i].dl, ~tbl[i].dl};
         do_txn($sformatf("vec%0d", i), tbl[i].req, dh, dl, tbl[i].dly, tbl[i].len,
                tbl[i].rd, tbl[i].win, tbl[i].err, tbl[i].exp_rd, tbl[i].lat);
      end

      // Reset in the middle of WAIT_DONE
      req_i = 2'b01; m_dly = 2; m_len = 60; dat_h_i = $urandom; dat_l_i = $urandom;
      repeat (12) @(negedge clk);
      chk("rst_busy_before", {busy_o, gnt_o}, 3'b101);
      rstn_i = 1'b0; req_i = 2'b00;
      @(negedge clk);
      chk("rst_mid_outs", {gnt_o, done_o, err_o, rd_dat_o, busy_o, spi_start_o, spi_wr_h_o, spi_wr_l_o}, 64'h0);
      @(negedge clk);
      rstn_i = 1'b1;
      n_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done_o != 2'b00 || busy_o) n_seen++;
      end
      chk("rst_no_done", n_seen, 0);
      do_txn("rst_first", 2'b11, 32'hAAAA_5555, 32'h3333_CCCC, 1, 2, 16'h4242, 0, 1'b0, 16'h4242, 4);

      // Randomized transactions against the reference model
      ref_last = 0; ref_rd = 16'h4242;
      for (int it = 0; it < 40; it++) begin
         rq  = 2'($urandom_range(1, 3));
         dh  = $urandom; dl = $urandom; rd = 16'($urandom);
         dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 20));
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(98, 103)) : int'($urandom_range(1, 30));
         win = ref_last; found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            if (!found && rq[(ref_last + k) % NREQ]) begin
               win = (ref_last + k) % NREQ;
               found = 1'b1;
            end
         end
         if (dly < 0 || dly > START_TO) begin
            err = 1'b1; lat = START_TO + 1;
         end else if (len <= DONE_TO) begin
            err = 1'b0; lat = dly + len + 1;
         end else begin
            err = 1'b1; lat = dly + DONE_TO + 1;
         end
         if (!err) ref_rd = rd;
         do_txn($sformatf("rnd%0d", it), rq, dh, dl, dly, len, rd, win, err, ref_rd, lat);
         ref_last = win;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_share_arb.md
# spi_share_arb

Round-robin arbiter and transaction sequencer that shares the single housekeeping `spi_master` instance between several requesters, such as the bus-register path and an ADC/PLL init sequencer. It sits between the requesters and `spi_master`. It latches one requester's command words, pulses the master's start, tracks `sts_spi_busy_o` with timeouts, and returns read data plus a done/error strobe to the granted requester only.

## Interface

- `NREQ`, default 2: number of requesters (1..8).
- `START_TO`, default 16: max cycles from `spi_start_o` to busy rising.
- `DONE_TO`, default 100000: max cycles busy may stay high.
- `clk_i`, in, 1: system clock. One clock only.
- `rstn_i`, in, 1: reset; synchronous, active-low.
- `req_i`, in, NREQ: request per requester; level, held until its `done_o` bit.
- `dat_h_i`, in, 16*NREQ: high command word per requester; slice i = [16i+15:16i]; bit 15 = read flag.
- `dat_l_i`, in, 16*NREQ: low command word per requester.
- `gnt_o`, out, NREQ: one-hot grant, high from LOAD through DONE inclusive.
- `done_o`, out, NREQ: one-cycle completion strobe to the granted requester.
- `err_o`, out, 1: valid with any `done_o` bit; 1 = timeout.
- `rd_dat_o`, out, 16: read data, valid with `done_o`, held until the next DONE.
- `busy_o`, out, 1: FSM not in IDLE.
- `spi_start_o`, out, 1: to `spi_start_i`.
- `spi_wr_h_o`, out, 16: to `dat_wr_h_i` and, via bit 15, `cfg_rw_i`.
- `spi_wr_l_o`, out, 16: to `dat_wr_l_i`.
- `spi_rd_l_i`, in, 16: from `dat_rd_l_o`.
- `spi_bsy_i`, in, 1: from `sts_spi_busy_o`.

## Operation

- FSM states: IDLE, LOAD, START, WAIT_BSY, WAIT_DONE, DONE.
- **IDLE**
  - If any `req_i` bit is set, pick a winner by round-robin, starting the search at `last+1` mod NREQ.
  - `last` is the last granted index; its reset value is NREQ-1, so requester 0 wins first.
  - Go to LOAD.
- **LOAD**
  - Register `gnt_o` and `last`.
  - Copy the winner's `dat_h_i`/`dat_l_i` slices into `spi_wr_h_o`/`spi_wr_l_o`.
  - The copied values stay stable until the next LOAD.
- **START**: `spi_start_o`=1 for exactly this cycle; clear the timeout counter; go to WAIT_BSY.
- **WAIT_BSY**
  - `spi_bsy_i`=1: go to WAIT_DONE with the counter cleared.
  - Counter reaches START_TO-1: set the error flag and go to DONE.
- **WAIT_DONE**
  - `spi_bsy_i`=0: capture `spi_rd_l_i` into `rd_dat_o`, clear the error flag, go to DONE.
  - Counter reaches DONE_TO-1: set the error flag and go to DONE; `rd_dat_o` is not updated.
- **DONE**
  - Assert `done_o[gnt]`=1 and `err_o`=flag.
  - Next cycle: return to IDLE and clear `gnt_o`.
- Requester rule:
  - The requester drops `req_i` in the cycle it sees `done_o`.
  - A request still high in IDLE is treated as a new transaction.
  - Command words are sampled only in LOAD. Changes after LOAD are ignored.
- A request dropped before grant is simply not served. Dropping a request after grant does not abort the transaction.
- Timeout counter is `$clog2(DONE_TO+1)` bits and saturates; no wrap.
- Reset values:
  - All outputs 0: `gnt_o`, `done_o`, `err_o`, `rd_dat_o`, `busy_o`, `spi_start_o`, `spi_wr_h_o`, `spi_wr_l_o`.
  - FSM=IDLE, `last`=NREQ-1.
- Reset mid-transaction returns the FSM to IDLE the next edge, with no `done_o`. `spi_master` shares the reset.

## Timing

- Grant latency: a request seen in IDLE at cycle n gives `gnt_o` at n+1 (LOAD) and `spi_start_o` at n+2.
- Completion: busy falling seen at cycle m gives `done_o` and `rd_dat_o` at m+1. The FSM is in IDLE at m+2, and the earliest next start is m+4.
- Fixed overhead per transaction: 5 cycles plus the master's busy time.
- Simultaneous requests: one grant per transaction, round-robin order. No requester waits more than NREQ-1 transactions.
- Busy already high at START (master not yet idle): treated as a valid rise; next state WAIT_DONE.
- Busy glitch low for one cycle in WAIT_DONE: ends the transaction. No filtering.

## Test plan

- **Single write, requester 0**: `dat_h`=0x0012, `dat_l`=0x00A5, model busy high cycles 3..50 after start. Expect: `spi_start_o` one pulse 2 cycles after `req_i`; `spi_wr_h_o`=0x0012; `done_o`=01 one cycle after busy falls; `err_o`=0.
- **Read, requester 1**: `dat_h`=0x8001, model returns 0x00C3. Expect `rd_dat_o`=0x00C3 with `done_o`=10.
- **Contention**: both `req_i` high from reset, each re-requesting immediately. Expect grant order 0,1,0,1; `gnt_o` always one-hot; `spi_start_o` count equals `done_o` count.
- **Start timeout**: busy never rises. Expect `done_o` START_TO+1 cycles after start with `err_o`=1, and `rd_dat_o` unchanged.
- **Busy stuck**: DONE_TO set to 100 for the sim, busy held high. Expect `err_o`=1 at the timeout, then the next request is served normally.
- **Reset mid-WAIT_DONE**: expect all outputs 0 on the next edge, no `done_o`, and after release requester 0 granted first.
